apb_rr_master: RTL and testbench

APB_RR_MASTER -- requirements
Module: apb_rr_master

---
 rtl/apb_rr_master.sv | 171 +++++++++++++++++
 tb/tb_apb_rr_master.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_rr_master.sv
// apb_rr_master: two-requester round-robin APB master with a wait-state timeout.
// req_ready is the only combinational output; everything else is registered.
module apb_rr_master #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned ADDR_W         = 32
) (
  input  logic                pclk,
  input  logic                presetn,
  input  logic [1:0]          req_valid,
  input  logic [1:0]          req_write,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [63:0]         req_wdata,
  output logic [1:0]          req_ready,
  output logic [1:0]          rsp_valid,
  output logic [31:0]         rsp_rdata,
  output logic                rsp_err,
  output logic [ADDR_W-1:0]   paddr,
  output logic                psel,
  output logic                penable,
  output logic                pwrite,
  output logic [31:0]         pwdata,
  input  logic [31:0]         prdata,
  input  logic                pready,
  input  logic                pslverr
);

  localparam int unsigned      CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t             r_state,     w_state_nxt;
  logic               r_last,      w_last_nxt;
  logic               r_gnt,       w_gnt_nxt;
  logic [CNT_W-1:0]   r_wait,      w_wait_nxt;
  logic               r_psel,      w_psel_nxt;
  logic               r_penable,   w_penable_nxt;
  logic               r_pwrite,    w_pwrite_nxt;
  logic [ADDR_W-1:0]  r_paddr,     w_paddr_nxt;
  logic [31:0]        r_pwdata,    w_pwdata_nxt;
  logic [1:0]         r_rsp_valid, w_rsp_valid_nxt;
  logic [31:0]        r_rsp_rdata, w_rsp_rdata_nxt;
  logic               r_rsp_err,   w_rsp_err_nxt;
  logic               w_sel;
  logic [1:0]         w_ready;

  // Round-robin pick: on a tie the requester not granted last wins.
  always_comb begin
    w_sel = 1'b0;
    if (req_valid == 2'b11) begin
      w_sel = ~r_last;
    end else if (req_valid[1]) begin
      w_sel = 1'b1;
    end
  end

  // Next-state and next-output decode for the IDLE/SETUP/ACCESS sequence.
  always_comb begin
    w_state_nxt     = r_state;
    w_last_nxt      = r_last;
    w_gnt_nxt       = r_gnt;
    w_wait_nxt      = r_wait;
    w_psel_nxt      = r_psel;
    w_penable_nxt   = r_penable;
    w_pwrite_nxt    = r_pwrite;
    w_paddr_nxt     = r_paddr;
    w_pwdata_nxt    = r_pwdata;
    w_rsp_valid_nxt = 2'b00;
    w_rsp_rdata_nxt = r_rsp_rdata;
    w_rsp_err_nxt   = r_rsp_err;
    w_ready         = 2'b00;
    case (r_state)
      S_IDLE: begin
        if (|req_valid) begin
          w_ready[w_sel] = 1'b1;
          w_state_nxt    = S_SETUP;
          w_last_nxt     = w_sel;
          w_gnt_nxt      = w_sel;
          w_wait_nxt     = '0;
          w_psel_nxt     = 1'b1;
          w_penable_nxt  = 1'b0;
          w_pwrite_nxt   = req_write[w_sel];
          w_paddr_nxt    = w_sel ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
          w_pwdata_nxt   = w_sel ? req_wdata[63:32] : req_wdata[31:0];
        end
      end
      S_SETUP: begin
        w_state_nxt   = S_ACCESS;
        w_penable_nxt = 1'b1;
      end
      S_ACCESS: begin
        if (pready) begin
          w_state_nxt            = S_IDLE;
          w_psel_nxt             = 1'b0;
          w_penable_nxt          = 1'b0;
          w_rsp_valid_nxt[r_gnt] = 1'b1;
          w_rsp_rdata_nxt        = r_pwrite ? 32'h0 : prdata;
          w_rsp_err_nxt          = pslverr;
        end else if (r_wait == WAIT_LAST) begin
          // Slave stalled too long: abort with an error response.
          w_state_nxt            = S_IDLE;
          w_psel_nxt             = 1'b0;
          w_penable_nxt          = 1'b0;
          w_rsp_valid_nxt[r_gnt] = 1'b1;
          w_rsp_rdata_nxt        = 32'h0;
          w_rsp_err_nxt          = 1'b1;
        end else begin
          w_wait_nxt = r_wait + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt   = S_IDLE;
        w_psel_nxt    = 1'b0;
        w_penable_nxt = 1'b0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Registered outputs, arbitration pointer and wait counter.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_last      <= 1'b1;
      r_gnt       <= 1'b0;
      r_wait      <= '0;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= 32'h0;
      r_rsp_valid <= 2'b00;
      r_rsp_rdata <= 32'h0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_last      <= w_last_nxt;
      r_gnt       <= w_gnt_nxt;
      r_wait      <= w_wait_nxt;
      r_psel      <= w_psel_nxt;
      r_penable   <= w_penable_nxt;
      r_pwrite    <= w_pwrite_nxt;
      r_paddr     <= w_paddr_nxt;
      r_pwdata    <= w_pwdata_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
    end
  end

  assign req_ready = presetn ? w_ready : 2'b00;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign paddr     = r_paddr;
  assign psel      = r_psel;
  assign penable   = r_penable;
  assign pwrite    = r_pwrite;
  assign pwdata    = r_pwdata;

endmodule

// File: tb/tb_apb_rr_master.sv
// tb_apb_rr_master: transaction-timeline model of the APB master, directed
// scenarios followed by randomized traffic.
module tb_apb_rr_master;

  localparam int unsigned TO = 16;
  localparam int unsigned AW = 32;

  logic          pclk = 1'b0;
  logic          presetn;
  logic [1:0]    req_valid;
  logic [1:0]    req_write;
  logic [2*AW-1:0] req_addr;
  logic [63:0]   req_wdata;
  logic [1:0]    req_ready;
  logic [1:0]    rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic [AW-1:0] paddr;
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [31:0]   pwdata;
  logic [31:0]   prdata;
  logic          pready;
  logic          pslverr;

  always #5 pclk = ~pclk;

  apb_rr_master #(.TIMEOUT_CYCLES(TO), .ADDR_W(AW)) dut (
    .pclk(pclk), .presetn(presetn),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  // A command carries the number of pready-low ACCESS cycles the slave will insert.
  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int unsigned w;
  } cmd_t;

  cmd_t q0[$];
  cmd_t q1[$];
  bit   present [2];
  int   present_pct;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  // Model: a transfer granted in cycle g with N ACCESS cycles occupies
  // SETUP at g+1, ACCESS at g+2..g+1+N, and responds at g+2+N.
  bit          m_busy;
  int          m_g;
  int          m_n;
  bit          m_normal;
  cmd_t        m_cmd;
  bit          m_idx;
  bit          m_last;
  int          m_rsp_due;
  bit          m_rsp_idx;
  logic [31:0] m_rsp_rdata;
  bit          m_rsp_err;
  logic [31:0] mem [8];
  logic [31:0] cur_prdata;

  int          lg_gcyc[$];
  int          lg_gidx[$];
  int          lg_rcyc[$];
  logic [1:0]  lg_rvec[$];
  logic [31:0] lg_rdata[$];
  logic        lg_rerr[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int qsize(input int i);
    if (i == 0) return q0.size();
    return q1.size();
  endfunction

  function automatic cmd_t qfront(input int i);
    cmd_t c;
    if (i == 0) c = q0[0];
    else        c = q1[0];
    return c;
  endfunction

  task automatic qpop(input int i);
    if (i == 0) q0.delete(0);
    else        q1.delete(0);
  endtask

  task automatic qpush(input int i, input bit wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input int unsigned w);
    cmd_t c;
    c.wr = wr; c.addr = addr; c.wdata = wdata; c.w = w;
    if (i == 0) q0.push_back(c);
    else        q1.push_back(c);
  endtask

  function automatic int winner();
    if (present[0] && present[1]) return m_last ? 0 : 1;
    if (present[1]) return 1;
    return 0;
  endfunction

  task automatic check_cycle();
    int k;
    logic [1:0] exp_ready;
    logic [1:0] exp_rv;
    k = cyc - m_g;
    exp_ready = 2'b00;
    if (!m_busy && (present[0] || present[1])) exp_ready = (winner() == 1) ? 2'b10 : 2'b01;
    chk("req_ready", req_ready, exp_ready);
    chk("psel", psel, m_busy && k >= 1);
    chk("penable", penable, m_busy && k >= 2);
    if (m_busy) begin
      chk("paddr", paddr, m_cmd.addr);
      chk("pwrite", pwrite, m_cmd.wr);
      if (m_cmd.wr) chk("pwdata", pwdata, m_cmd.wdata);
    end
    exp_rv = 2'b00;
    if (m_rsp_due == cyc) exp_rv = m_rsp_idx ? 2'b10 : 2'b01;
    chk("rsp_valid", rsp_valid, exp_rv);
    if (m_rsp_due == cyc) begin
      chk("rsp_rdata", rsp_rdata, m_rsp_rdata);
      chk("rsp_err", rsp_err, m_rsp_err);
    end
    if (req_ready != 2'b00) begin
      lg_gcyc.push_back(cyc);
      lg_gidx.push_back(int'(req_ready[1]));
    end
    if (rsp_valid != 2'b00) begin
      lg_rcyc.push_back(cyc);
      lg_rvec.push_back(rsp_valid);
      lg_rdata.push_back(rsp_rdata);
      lg_rerr.push_back(rsp_err);
    end
  endtask

  task automatic model_update();
    int w;
    int idx;
    if (!m_busy && (present[0] || present[1])) begin
      w = winner();
      m_cmd = qfront(w);
      qpop(w);
      present[w] = 1'b0;
      m_last   = w[0];
      m_idx    = w[0];
      m_busy   = 1'b1;
      m_g      = cyc;
      m_normal = (m_cmd.w < TO);
      m_n      = m_normal ? int'(m_cmd.w) + 1 : int'(TO);
    end else if (m_busy && (cyc - m_g) == m_n + 1) begin
      idx = int'(m_cmd.addr[4:2]);
      if (m_normal) begin
        m_rsp_err   = (m_cmd.addr >= 32);
        m_rsp_rdata = m_cmd.wr ? 32'h0 : cur_prdata;
        if (m_cmd.wr && m_cmd.addr < 32) mem[idx] = m_cmd.wdata;
      end else begin
        m_rsp_err   = 1'b1;
        m_rsp_rdata = 32'h0;
      end
      m_rsp_idx = m_idx;
      m_rsp_due = cyc + 1;
      m_busy    = 1'b0;
    end
  endtask

  // One clock: drive requesters and slave, then compare and advance the model.
  task automatic step();
    int   k;
    int   idx;
    cmd_t c;
    @(posedge pclk);
    #1;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (!present[i] && qsize(i) > 0 && int'($urandom_range(99)) < present_pct) present[i] = 1'b1;
      if (present[i]) begin
        c = qfront(i);
        req_valid[i] = 1'b1;
        req_write[i] = c.wr;
        req_addr[i*AW +: AW]  = c.addr;
        req_wdata[i*32 +: 32] = c.wdata;
      end else begin
        req_valid[i] = 1'b0;
        req_write[i] = 1'($urandom);
        req_addr[i*AW +: AW]  = $urandom;
        req_wdata[i*32 +: 32] = $urandom;
      end
    end
    k = cyc - m_g;
    if (m_busy && k >= 2 && k <= m_n + 1) begin
      if (m_normal && k == m_n + 1) begin
        idx = int'(m_cmd.addr[4:2]);
        pready  = 1'b1;
        pslverr = (m_cmd.addr >= 32);
        prdata  = (!m_cmd.wr && m_cmd.addr < 32) ? mem[idx] : $urandom;
      end else begin
        pready  = 1'b0;
        pslverr = 1'($urandom);
        prdata  = $urandom;
      end
    end else begin
      pready  = 1'($urandom);
      pslverr = 1'($urandom);
      prdata  = $urandom;
    end
    cur_prdata = prdata;
    @(negedge pclk);
    check_cycle();
    model_update();
  endtask

  task automatic run_until_idle(input int max);
    int n = 0;
    while ((m_busy || qsize(0) > 0 || qsize(1) > 0 || m_rsp_due > cyc) && n < max) begin
      step();
      n++;
    end
    if (n >= max) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_bound: got %0d cycles, expected fewer than %0d", n, max);
    end
  endtask

  // Assert reset now, verify outputs drop without a clock, release on a falling edge.
  task automatic hold_reset(input string tag);
    presetn   = 1'b0;
    req_valid = 2'b11;
    #1;
    chk({tag, "_async_psel"}, psel, 1'b0);
    chk({tag, "_async_penable"}, penable, 1'b0);
    m_busy = 1'b0; m_last = 1'b1; m_rsp_due = -1;
    present[0] = 1'b0; present[1] = 1'b0;
    repeat (2) begin
      @(negedge pclk);
      chk({tag, "_psel"}, psel, 1'b0);
      chk({tag, "_penable"}, penable, 1'b0);
      chk({tag, "_rsp_valid"}, rsp_valid, 2'b00);
      chk({tag, "_req_ready"}, req_ready, 2'b00);
      chk({tag, "_pwrite"}, pwrite, 1'b0);
      chk({tag, "_paddr"}, paddr, 32'h0);
      chk({tag, "_pwdata"}, pwdata, 32'h0);
      chk({tag, "_rsp_rdata"}, rsp_rdata, 32'h0);
      chk({tag, "_rsp_err"}, rsp_err, 1'b0);
    end
    req_valid = 2'b00;
    presetn   = 1'b1;
  endtask

  // Literal expectations on the first transfer logged since (gb, rb).
  task automatic lit(input string tag, input int gb, input int rb, input int lat,
                     input logic [1:0] vec, input logic [31:0] rdata, input bit err);
    chk({tag, "_seen"}, (lg_gcyc.size() > gb) && (lg_rcyc.size() > rb), 1'b1);
    if (lg_gcyc.size() > gb && lg_rcyc.size() > rb) begin
      chk({tag, "_latency"}, lg_rcyc[rb] - lg_gcyc[gb], lat);
      chk({tag, "_vec"}, lg_rvec[rb], vec);
      chk({tag, "_rdata"}, lg_rdata[rb], rdata);
      chk({tag, "_err"}, lg_rerr[rb], err);
    end
  endtask

  initial begin
    int gb;
    int rb;
    int bound;
    presetn = 1'b1; req_valid = 2'b00; req_write = 2'b00; req_addr = '0; req_wdata = '0;
    prdata = 32'h0; pready = 1'b0; pslverr = 1'b0;
    m_busy = 1'b0; m_g = 0; m_n = 0; m_last = 1'b1; m_rsp_due = -1;
    for (int i = 0; i < 8; i++) mem[i] = 32'h0;
    present[0] = 1'b0; present[1] = 1'b0;
    present_pct = 100;
    #2;
    hold_reset("reset");

    // Single write, zero wait states.
    gb = lg_gcyc.size(); rb = lg_rcyc.size();
    qpush(0, 1'b1, 32'h04, 32'hA5A5_0001, 0);
    run_until_idle(50);
    lit("single_write", gb, rb, 3, 2'b01, 32'h0, 1'b0);

    // Read back from requester 1 with three wait states.
    gb = lg_gcyc.size(); rb = lg_rcyc.size();
    qpush(1, 1'b0, 32'h04, 32'h0, 3);
    run_until_idle(50);
    lit("read_waits", gb, rb, 6, 2'b10, 32'hA5A5_0001, 1'b0);

    // Out-of-range read forwarded with the slave error.
    gb = lg_gcyc.size(); rb = lg_rcyc.size();
    qpush(0, 1'b0, 32'h40, 32'h0, 1);
    run_until_idle(50);
    lit("slave_err", gb, rb, 4, 2'b01, lg_rdata.size() > rb ? lg_rdata[rb] : 32'h0, 1'b1);

    // Timeout, then pready arriving on the last allowed wait cycle.
    gb = lg_gcyc.size(); rb = lg_rcyc.size();
    qpush(0, 1'b0, 32'h08, 32'h0, TO);
    run_until_idle(80);
    lit("timeout", gb, rb, 18, 2'b01, 32'h0, 1'b1);
    gb = lg_gcyc.size(); rb = lg_rcyc.size();
    qpush(0, 1'b1, 32'h08, 32'h1234_5678, TO - 1);
    run_until_idle(80);
    lit("late_pready", gb, rb, 18, 2'b01, 32'h0, 1'b0);

    // Contention after reset: strict alternation starting with requester 0.
    hold_reset("reset2");
    gb = lg_gcyc.size();
    for (int i = 0; i < 2; i++) begin
      qpush(0, 1'b0, 32'h04, 32'h0, 0);
      qpush(1, 1'b0, 32'h0C, 32'h0, 0);
    end
    run_until_idle(80);
    chk("contention_grants", lg_gcyc.size() - gb, 4);
    if (lg_gcyc.size() - gb >= 4) begin
      chk("contention_g0", lg_gidx[gb],     0);
      chk("contention_g1", lg_gidx[gb + 1], 1);
      chk("contention_g2", lg_gidx[gb + 2], 0);
      chk("contention_g3", lg_gidx[gb + 3], 1);
    end

    // Reset in the middle of ACCESS abandons the transfer.
    qpush(1, 1'b1, 32'h10, 32'hDEAD_BEEF, 10);
    bound = 0;
    while (!(m_busy && (cyc - m_g) == 4) && bound < 30) begin
      step();
      bound++;
    end
    chk("mid_reset_reached_access", penable, 1'b1);
    #2;
    hold_reset("mid_reset");
    gb = lg_gcyc.size();
    qpush(0, 1'b0, 32'h00, 32'h0, 0);
    qpush(1, 1'b0, 32'h04, 32'h0, 0);
    run_until_idle(60);
    chk("post_reset_tie_seen", lg_gcyc.size() > gb, 1'b1);
    if (lg_gcyc.size() > gb) chk("post_reset_tie_winner", lg_gidx[gb], 0);

    // Randomized traffic.
    present_pct = 60;
    for (int n = 0; n < 600; n++) begin
      int i;
      int r;
      int unsigned w;
      i = int'($urandom_range(1));
      if ($urandom_range(2) == 0 && qsize(i) < 3) begin
        r = int'($urandom_range(9));
        w = (r < 7) ? $urandom_range(3) : $urandom_range(TO + 1, TO - 2);
        qpush(i, 1'($urandom), {26'h0, 4'($urandom_range(15)), 2'b00}, $urandom, w);
      end
      step();
    end
    run_until_idle(400);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
